// File: rtl/onehot_arbiter.sv
// onehot_arbiter: 8-way round-robin arbiter with a registered one-hot grant,
// a binary grant index, and a hold timeout that forcibly revokes a grant
// held for TIMEOUT cycles without release. Every grant is followed by a
// one-cycle GAP state.
//
// Optional feature macro: ARB_SLOT1_EN
//   undefined (default) : requester 1 is never eligible; index 1 is skipped
//   defined             : requester 1 takes part in round-robin like the rest
module onehot_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] gnt,
   output logic [2:0] gnt_sel,
   output logic       gnt_valid,
   output logic       timeout
);

   // Hold limit at the width of the hold counter (legal range 2..255).
   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   // Requesters allowed to win arbitration; bit 1 is masked in the default build.
`ifdef ARB_SLOT1_EN
   localparam logic [7:0] ELIG_MASK = 8'hFF;
`else
   localparam logic [7:0] ELIG_MASK = 8'hFD;
`endif

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t       state_r;
   logic [7:0]   counter_r;
   logic [2:0]   last_idx_r;

   logic [7:0]   elig_s;
   logic [3:0]   pick_s;
   logic         pick_found_s;
   logic [2:0]   pick_idx_s;
   logic         owner_req_s;
   logic         hold_expired_s;
   logic         release_s;
   logic         revoke_s;

   // Round-robin search: start one past the last winner and walk upward with
   // wrap; the first eligible index wins. Result is {found, index}.
   function automatic logic [3:0] rr_pick(input logic [7:0] elig,
                                          input logic [2:0] last);
      logic [3:0] res;
      logic [2:0] cand;
      res = 4'b0000;
      for (int k = 1; k <= 8; k++) begin
         cand = last + 3'(k);
         if (!res[3] && elig[cand]) begin
            res = {1'b1, cand};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   // 3-to-8 decode of the grant index into the one-hot grant vector.
   function automatic logic [7:0] onehot8(input logic [2:0] idx);
      return 8'h01 << idx;
   endfunction

   // Arbitration and release decisions for the current cycle.
   always_comb begin
      elig_s         = 8'h00;
      pick_s         = 4'b0000;
      pick_found_s   = 1'b0;
      pick_idx_s     = 3'd0;
      owner_req_s    = 1'b0;
      hold_expired_s = 1'b0;
      release_s      = 1'b0;
      revoke_s       = 1'b0;

      elig_s         = req & ELIG_MASK;
      pick_s         = rr_pick(elig_s, last_idx_r);
      pick_found_s   = pick_s[3];
      pick_idx_s     = pick_s[2:0];
      owner_req_s    = req[gnt_sel];
      hold_expired_s = (counter_r == TIMEOUT_C);
      if (state_r == ST_GRANT) begin
         release_s = done || !owner_req_s || hold_expired_s;
         // Timeout only when the limit is the sole reason for the exit.
         revoke_s  = hold_expired_s && !done && owner_req_s;
      end else begin
         release_s = 1'b0;
         revoke_s  = 1'b0;
      end
   end

   // Arbiter FSM with registered grant, index, valid and timeout outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         gnt        <= 8'h00;
         gnt_sel    <= 3'd0;
         gnt_valid  <= 1'b0;
         timeout    <= 1'b0;
         counter_r  <= 8'd0;
         last_idx_r <= 3'd7;
      end else begin
         case (state_r)
            ST_IDLE: begin
               timeout <= 1'b0;
               if (pick_found_s) begin
                  state_r    <= ST_GRANT;
                  gnt        <= onehot8(pick_idx_s);
                  gnt_sel    <= pick_idx_s;
                  gnt_valid  <= 1'b1;
                  counter_r  <= 8'd1;
                  last_idx_r <= pick_idx_s;
               end else begin
                  state_r    <= ST_IDLE;
               end
            end

            ST_GRANT: begin
               if (release_s) begin
                  state_r   <= ST_GAP;
                  gnt       <= 8'h00;
                  gnt_valid <= 1'b0;
                  timeout   <= revoke_s;
                  counter_r <= 8'd0;
               end else begin
                  timeout   <= 1'b0;
                  counter_r <= counter_r + 8'd1;
               end
            end

            ST_GAP: begin
               // Single dead cycle; done and requests are not acted on here.
               state_r   <= ST_IDLE;
               timeout   <= 1'b0;
            end

            default: begin
               state_r   <= ST_IDLE;
               gnt       <= 8'h00;
               gnt_valid <= 1'b0;
               timeout   <= 1'b0;
               counter_r <= 8'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_onehot_arbiter.sv
// Self-checking bench for onehot_arbiter: directed scenarios plus a random
// run, all compared against an abstract owner/cool-down reference model.
module tb_onehot_arbiter;

   localparam int TB_TIMEOUT = 16;
`ifdef ARB_SLOT1_EN
   localparam bit SLOT1 = 1'b1;
`else
   localparam bit SLOT1 = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = 8'h00;
   logic       done = 1'b0;
   logic [7:0] gnt;
   logic [2:0] gnt_sel;
   logic       gnt_valid;
   logic       timeout;

   int errors = 0;
   int checks = 0;

   // reference model state
   int m_owner = -1;   // current owner index, -1 when nobody holds a grant
   int m_held  = 0;    // cycles the owner has held the grant
   int m_cool  = 0;    // dead cycles still to pass before arbitration
   int m_last  = 7;    // last winner
   int m_sel   = 0;    // index shown on gnt_sel
   bit m_to    = 1'b0; // expected timeout pulse

   onehot_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .done     (done),
      .gnt      (gnt),
      .gnt_sel  (gnt_sel),
      .gnt_valid(gnt_valid),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] exp_gnt();
      if (m_owner >= 0) return 8'(1 << m_owner);
      else return 8'h00;
   endfunction

   // advance the model by one clock edge using the inputs present at the edge
   function automatic void model_update();
      int idx;
      bit owner_wants;
      if (rst) begin
         m_owner = -1; m_held = 0; m_cool = 0; m_last = 7; m_sel = 0; m_to = 1'b0;
      end else if (m_owner >= 0) begin
         owner_wants = req[m_owner];
         if (done || !owner_wants || m_held == TB_TIMEOUT) begin
            m_to = !done && owner_wants;
            m_owner = -1; m_held = 0; m_cool = 1;
         end else begin
            m_held++; m_to = 1'b0;
         end
      end else if (m_cool > 0) begin
         m_cool--; m_to = 1'b0;
      end else begin
         m_to = 1'b0;
         for (int k = 1; k <= 8; k++) begin
            idx = (m_last + k) % 8;
            if (m_owner < 0 && req[idx] && (idx != 1 || SLOT1)) begin
               m_owner = idx; m_sel = idx; m_last = idx; m_held = 1;
            end
         end
      end
   endfunction

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 8'hFF; done = 1'b1;
      step();
      step();
      checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt: got %h want 00", gnt); end
      checks++; if (gnt_sel !== 3'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", gnt_sel); end
      checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", gnt_valid); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
      done = 1'b0; req = 8'h00;
   endtask

   task automatic test_basic();
      rst = 1'b1; step(); rst = 1'b0;
      req = 8'h01; step();
      checks++; if (gnt !== 8'h01 || gnt_sel !== 3'd0 || gnt_valid !== 1'b1) begin
         errors++; $display("FAIL basic_grant: got gnt=%h sel=%0d v=%b want 01/0/1", gnt, gnt_sel, gnt_valid); end
      done = 1'b1; step(); done = 1'b0;
      checks++; if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
         errors++; $display("FAIL basic_release: got gnt=%h v=%b to=%b want 00/0/0", gnt, gnt_valid, timeout); end
      step();
      checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL basic_gap2: got %h want 00", gnt); end
      step();
      checks++; if (gnt !== 8'h01 || gnt_valid !== 1'b1) begin
         errors++; $display("FAIL basic_regrant: got gnt=%h v=%b want 01/1", gnt, gnt_valid); end
      req = 8'h00; step(); step(); step();
   endtask

   task automatic test_round_robin();
      int order[$];
      int w;
      if (SLOT1) order = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
      else       order = '{0, 2, 3, 4, 5, 6, 7, 0};
      rst = 1'b1; step(); rst = 1'b0;
      req = 8'hFF;
      foreach (order[n]) begin
         w = 0;
         while (gnt_valid !== 1'b1 && w < 6) begin step(); w++; end
         checks++; if (gnt_sel !== 3'(order[n]) || gnt !== 8'(1 << order[n])) begin
            errors++; $display("FAIL rr_order[%0d]: got sel=%0d gnt=%h want sel=%0d", n, gnt_sel, gnt, order[n]); end
         done = 1'b1; step(); done = 1'b0;
      end
      req = 8'h00; step(); step(); step();
   endtask

   task automatic test_timeout();
      int cnt;
      rst = 1'b1; step(); rst = 1'b0;
      req = 8'h04; step();
      cnt = 0;
      while (gnt === 8'h04 && cnt < TB_TIMEOUT + 5) begin cnt++; step(); end
      checks++; if (cnt != TB_TIMEOUT) begin errors++; $display("FAIL timeout_len: got %0d want %0d", cnt, TB_TIMEOUT); end
      checks++; if (gnt !== 8'h00 || timeout !== 1'b1) begin
         errors++; $display("FAIL timeout_pulse: got gnt=%h to=%b want 00/1", gnt, timeout); end
      step();
      checks++; if (timeout !== 1'b0 || gnt !== 8'h00) begin
         errors++; $display("FAIL timeout_once: got gnt=%h to=%b want 00/0", gnt, timeout); end
      req = 8'h00; step(); step();
   endtask

   task automatic test_withdraw();
      rst = 1'b1; step(); rst = 1'b0;
      req = 8'h08; step();
      checks++; if (gnt !== 8'h08 || gnt_sel !== 3'd3) begin
         errors++; $display("FAIL wd_grant: got gnt=%h sel=%0d want 08/3", gnt, gnt_sel); end
      req = 8'h18; step(); step();
      checks++; if (gnt !== 8'h08) begin errors++; $display("FAIL wd_hold: got %h want 08", gnt); end
      req = 8'h00; step();
      checks++; if (gnt !== 8'h00 || timeout !== 1'b0) begin
         errors++; $display("FAIL wd_drop: got gnt=%h to=%b want 00/0", gnt, timeout); end
      step();
      checks++; if (timeout !== 1'b0 || gnt_valid !== 1'b0) begin
         errors++; $display("FAIL wd_gap: got to=%b v=%b want 0/0", timeout, gnt_valid); end
      step();
   endtask

   task automatic test_reset_mid_grant();
      rst = 1'b1; step(); rst = 1'b0;
      req = 8'h80; step();
      checks++; if (gnt !== 8'h80 || gnt_sel !== 3'd7) begin
         errors++; $display("FAIL rm_grant: got gnt=%h sel=%0d want 80/7", gnt, gnt_sel); end
      step();
      rst = 1'b1; done = 1'b1; step(); rst = 1'b0; done = 1'b0;
      checks++; if (gnt !== 8'h00 || gnt_sel !== 3'd0 || timeout !== 1'b0 || gnt_valid !== 1'b0) begin
         errors++; $display("FAIL rm_reset: got gnt=%h sel=%0d to=%b v=%b want 00/0/0/0", gnt, gnt_sel, timeout, gnt_valid); end
      step();
      checks++; if (gnt !== 8'h80 || gnt_sel !== 3'd7) begin
         errors++; $display("FAIL rm_regrant: got gnt=%h sel=%0d want 80/7", gnt, gnt_sel); end
      req = 8'h00; step(); step(); step();
   endtask

   task automatic test_random();
      logic [7:0] eg;
      rst = 1'b1; step(); rst = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(7, 0) == 0) req = 8'($urandom);
         done = ($urandom_range(5, 0) == 0);
         rst  = ($urandom_range(99, 0) == 0);
         step();
         eg = exp_gnt();
         checks++; if (gnt !== eg) begin errors++; $display("FAIL rnd_gnt@%0d: got %h want %h", c, gnt, eg); end
         checks++; if (gnt_sel !== 3'(m_sel)) begin errors++; $display("FAIL rnd_sel@%0d: got %0d want %0d", c, gnt_sel, m_sel); end
         checks++; if (gnt_valid !== (m_owner >= 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", c, gnt_valid, m_owner >= 0); end
         checks++; if (timeout !== m_to) begin errors++; $display("FAIL rnd_timeout@%0d: got %b want %b", c, timeout, m_to); end
         checks++; if ($countones(gnt) > 1 || (gnt_valid === 1'b1 && gnt !== (8'h01 << gnt_sel)) ||
                       (gnt_valid === 1'b0 && gnt !== 8'h00) || (!SLOT1 && gnt_valid === 1'b1 && gnt_sel === 3'd1)) begin
            errors++; $display("FAIL rnd_onehot@%0d: got gnt=%h sel=%0d v=%b", c, gnt, gnt_sel, gnt_valid); end
      end
      rst = 1'b0; done = 1'b0; req = 8'h00;
   endtask

   initial begin
      #2;
      test_reset();
      test_basic();
      test_round_robin();
      test_timeout();
      test_withdraw();
      test_reset_mid_grant();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/onehot_arbiter.md
ONEHOT_ARBITER -- requirements
Module: onehot_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 16, max cycles a grant is held without release (legal 2..255).
REQ-002 Port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 Port: rst  input  1  synchronous active-high reset, sampled on clk rising edge.
REQ-004 Port: req  input  8  per-requester request, bit i = requester i.
REQ-005 Port: done  input  1  current owner releases grant.
REQ-006 Port: gnt  output  8  registered one-hot grant, zero when idle.
REQ-007 Port: gnt_sel  output  3  binary index of the current grant, driving the 3-to-8 select.
REQ-008 Port: gnt_valid  output  1  high while any grant is held.
REQ-009 Port: timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-010 FSM states SHALL be IDLE, GRANT, GAP; encoding is implementation choice.
REQ-011 IDLE: if any eligible req bit is set, the next edge SHALL enter GRANT with gnt/gnt_sel/gnt_valid registered (latency 1 cycle from req to gnt).
REQ-012 Eligible set SHALL be req with bit 1 masked to 0 unless ARB_SLOT1_EN is defined.
REQ-013 Selection SHALL be round-robin: search starts at (last_idx+1) mod 8, ascending with wrap 7->0; first eligible bit wins.
REQ-014 last_idx SHALL update to the granted index on entry to GRANT.
REQ-015 gnt SHALL equal exactly 1<<gnt_sel whenever gnt_valid=1, and 8'h00 otherwise; gnt_sel SHALL hold its last value when idle.
REQ-016 GRANT: hold cycle counter SHALL start at 1 on entry and increment each cycle in GRANT.
REQ-017 GRANT exits to GAP on the edge where any of: done=1; req[gnt_sel]=0; counter==TIMEOUT.
REQ-018 Exit by counter==TIMEOUT with done=0 and req[gnt_sel]=1 SHALL pulse timeout for exactly the cycle after that edge; done or withdrawal in the same cycle suppresses timeout.
REQ-019 On exit, gnt and gnt_valid SHALL be 0 from the next cycle.
REQ-020 GAP SHALL last exactly one cycle, then return to IDLE; no grant issues in GAP, so back-to-back grants are separated by at least two cycles of gnt=0.
REQ-021 done asserted while IDLE or GAP SHALL be ignored.
REQ-022 req changes during GRANT other than the owner's bit SHALL not affect the current grant.
REQ-023 At most one gnt bit SHALL be high in any cycle, including the cycle after reset.

Reset
REQ-024 rst=1 SHALL, at the next edge, force IDLE, gnt=8'h00, gnt_sel=3'd0, gnt_valid=0, timeout=0, counter=0, last_idx=7 (first search begins at 0).
REQ-025 rst asserted mid-GRANT SHALL drop the grant at that edge with no timeout pulse and no GAP cycle.
REQ-026 rst SHALL take priority over all other inputs in the same cycle.

Configuration
REQ-027 Macro ARB_SLOT1_EN: when defined, requester 1 is eligible and can receive gnt=8'h02, gnt_sel=3'd1.
REQ-028 Without ARB_SLOT1_EN, req[1] SHALL be ignored and gnt_sel SHALL never equal 3'd1 (that decoder output is unused); the round-robin search skips index 1.

Verification
REQ-029 Reset then req=8'h01 -> after 1 cycle gnt=8'h01, gnt_sel=0, gnt_valid=1; done=1 for one cycle -> gnt=8'h00 next cycle, 1 GAP cycle.
REQ-030 req=8'hFF held, done pulsed each grant, macro undefined -> grant order 0,2,3,4,5,6,7,0; with ARB_SLOT1_EN -> 0,1,2,...,7,0.
REQ-031 req=8'h04, done never asserted, TIMEOUT=16 -> gnt=8'h04 for 16 cycles, then gnt=0 and timeout=1 for one cycle.
REQ-032 Owner at index 3, req drops to 8'h00 mid-grant -> gnt=0 next cycle, timeout stays 0, FSM passes GAP to IDLE.
REQ-033 rst=1 during GRANT with req=8'h80 -> next cycle gnt=0, gnt_sel=0, timeout=0; after rst release grant goes to index 7 (search from 0, first eligible).
REQ-034 Every cycle of all scenarios: gnt is one-hot or zero and equals 1<<gnt_sel when gnt_valid=1.
